// File: rtl/synth_pkg.sv
// Shared widths and FSM encoding for the voice allocator and the voice demux.
package synth_pkg;

    localparam int unsigned NUM_VOICES = 24;
    localparam int unsigned SEL_W      = 5;
    localparam int unsigned NOTE_W     = 7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_WRITE  = 2'd2,
        ST_PANIC  = 2'd3
    } state_t;

    // Latched note event; packs exactly as the demux data word {gate, note}.
    typedef struct packed {
        logic              on;
        logic [NOTE_W-1:0] note;
    } note_ev_t;

endpackage

// File: rtl/voice_find.sv
// Lowest-index priority encoder over a per-voice flag vector.
module voice_find
    import synth_pkg::*;
(
    input  logic [NUM_VOICES-1:0] vec,
    output logic                  found,
    output logic [SEL_W-1:0]      idx
);

    // Scan downward so the lowest set index is the last one written.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (vec[i]) begin
                found = 1'b1;
                idx   = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Assigns note events to voice slots and drives one demux write per event;
// a panic sweep writes every slot with a silent word.
module voice_allocator
    import synth_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ev_valid,
    output logic                  ev_ready,
    input  logic                  ev_on,
    input  logic [NOTE_W-1:0]     ev_note,
    input  logic                  panic,
    output logic [SEL_W-1:0]      dm_sel,
    output logic [NOTE_W:0]       dm_data,
    output logic                  dm_we,
    output logic [NUM_VOICES-1:0] voice_active,
    output logic                  steal
);

    state_t                  state;
    note_ev_t                ev_q;
    logic [NUM_VOICES-1:0]   active;
    logic [NOTE_W-1:0]       note_tbl [NUM_VOICES];
    logic [SEL_W-1:0]        steal_ptr;

    logic [NUM_VOICES-1:0]   match_vec;
    logic [NUM_VOICES-1:0]   free_vec;
    logic                    m_found;
    logic [SEL_W-1:0]        m_idx;
    logic                    f_found;
    logic [SEL_W-1:0]        f_idx;

    logic                    tgt_hit;
    logic                    tgt_steal;
    logic [SEL_W-1:0]        tgt_sel;

    always_comb begin
        match_vec = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            match_vec[i] = active[i] & (note_tbl[i] == ev_q.note);
        end
        free_vec = ~active;
    end

    voice_find u_find_match (
        .vec   (match_vec),
        .found (m_found),
        .idx   (m_idx)
    );

    voice_find u_find_free (
        .vec   (free_vec),
        .found (f_found),
        .idx   (f_idx)
    );

    // Target resolution: retrigger, then free voice, then steal; note-off needs a match.
    always_comb begin
        tgt_hit   = 1'b0;
        tgt_steal = 1'b0;
        tgt_sel   = '0;
        if (ev_q.on) begin
            tgt_hit = 1'b1;
            if (m_found) begin
                tgt_sel = m_idx;
            end else if (f_found) begin
                tgt_sel = f_idx;
            end else begin
                tgt_sel   = steal_ptr;
                tgt_steal = 1'b1;
            end
        end else if (m_found) begin
            tgt_hit = 1'b1;
            tgt_sel = m_idx;
        end
    end

    assign ev_ready     = (state == ST_IDLE) & ~panic;
    assign voice_active = active;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            ev_q      <= '0;
            dm_sel    <= '0;
            dm_data   <= '0;
            dm_we     <= 1'b0;
            steal     <= 1'b0;
            active    <= '0;
            steal_ptr <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_tbl[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    dm_we <= 1'b0;
                    steal <= 1'b0;
                    if (panic) begin
                        state   <= ST_PANIC;
                        dm_we   <= 1'b1;
                        dm_sel  <= '0;
                        dm_data <= '0;
                    end else if (ev_valid) begin
                        ev_q.on   <= ev_on;
                        ev_q.note <= ev_note;
                        state     <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (tgt_hit) begin
                        state   <= ST_WRITE;
                        dm_we   <= 1'b1;
                        dm_sel  <= tgt_sel;
                        dm_data <= ev_q;
                        steal   <= tgt_steal;
                        if (tgt_steal) begin
                            steal_ptr <= (steal_ptr == SEL_W'(NUM_VOICES - 1))
                                         ? '0 : steal_ptr + SEL_W'(1);
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    // Tables commit as the demux write completes.
                    dm_we          <= 1'b0;
                    steal          <= 1'b0;
                    active[dm_sel] <= ev_q.on;
                    if (ev_q.on) begin
                        note_tbl[dm_sel] <= ev_q.note;
                    end
                    state <= ST_IDLE;
                end
                ST_PANIC: begin
                    active[dm_sel] <= 1'b0;
                    if (dm_sel == SEL_W'(NUM_VOICES - 1)) begin
                        dm_we <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        dm_sel <= dm_sel + SEL_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    dm_we <= 1'b0;
                    steal <= 1'b0;
                end
            endcase
        end
    end

endmodule
